// File: rtl/conv_stream_host.sv
// Stream-side host for a convolver: loads one input vector, streams it out on x,
// then collects LENX-LENF+1 results from y into a readable result buffer.
module conv_stream_host #(
   parameter int WIDTH = 8,
   parameter int LENX  = 8,
   parameter int LENF  = 4,
   parameter int LOGX  = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] load_data,
   input  logic             load_valid,
   output logic             load_ready,
   output logic [WIDTH-1:0] m_data_out_x,
   output logic             m_valid_x,
   input  logic             m_ready_x,
   input  logic [WIDTH-1:0] s_data_in_y,
   input  logic             s_valid_y,
   output logic             s_ready_y,
   input  logic [LOGX-1:0]  rd_addr,
   output logic [WIDTH-1:0] rd_data,
   output logic             busy,
   output logic             done
);

   localparam int SIZE = LENX - LENF + 1;
   localparam int CW   = LOGX + 1;

   localparam logic [CW-1:0] LAST_X = CW'(LENX - 1);
   localparam logic [CW-1:0] LAST_Y = CW'(SIZE - 1);
   localparam logic [CW-1:0] SIZE_C = CW'(SIZE);

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] LOAD = 3'd1;
   localparam logic [2:0] SEND = 3'd2;
   localparam logic [2:0] RECV = 3'd3;
   localparam logic [2:0] DONE = 3'd4;

   logic [2:0]       state;
   logic [CW-1:0]    lcnt;
   logic [CW-1:0]    xidx;
   logic [CW-1:0]    ycnt;
   logic [WIDTH-1:0] xbuf [LENX];
   logic [WIDTH-1:0] ybuf [SIZE];
   logic [WIDTH-1:0] rd_next;

   // Handshake outputs are pure state decodes so nothing combinational leaks from the inputs.
   assign load_ready   = (state == LOAD);
   assign m_valid_x    = (state == SEND);
   assign s_ready_y    = (state == RECV);
   assign busy         = (state != IDLE);
   assign done         = (state == DONE);
   assign m_data_out_x = (state == SEND) ? xbuf[xidx[LOGX-1:0]] : '0;

   always_comb begin
      rd_next = '0;
      if ({1'b0, rd_addr} < SIZE_C) begin
         rd_next = ybuf[rd_addr];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         lcnt    <= '0;
         xidx    <= '0;
         ycnt    <= '0;
         rd_data <= '0;
         for (int i = 0; i < LENX; i++) begin
            xbuf[i] <= '0;
         end
         for (int i = 0; i < SIZE; i++) begin
            ybuf[i] <= '0;
         end
      end else begin
         rd_data <= rd_next;
         case (state)
            IDLE: begin
               if (start) begin
                  state <= LOAD;
                  lcnt  <= '0;
               end
            end
            LOAD: begin
               if (load_valid) begin
                  xbuf[lcnt[LOGX-1:0]] <= load_data;
                  lcnt                 <= lcnt + CW'(1);
                  if (lcnt == LAST_X) begin
                     state <= SEND;
                     xidx  <= '0;
                  end
               end
            end
            SEND: begin
               if (m_ready_x) begin
                  xidx <= xidx + CW'(1);
                  if (xidx == LAST_X) begin
                     state <= RECV;
                     ycnt  <= '0;
                  end
               end
            end
            RECV: begin
               if (s_valid_y) begin
                  ybuf[ycnt[LOGX-1:0]] <= s_data_in_y;
                  ycnt                 <= ycnt + CW'(1);
                  if (ycnt == LAST_Y) begin
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_conv_stream_host.sv
// Directed bench for conv_stream_host: drives load/x/y handshakes on the falling
// edge and checks outputs there against hand-written vectors.
module tb_conv_stream_host;

   logic       clk;
   logic       reset;
   logic       start;
   logic [7:0] load_data;
   logic       load_valid;
   logic       load_ready;
   logic [7:0] m_data_out_x;
   logic       m_valid_x;
   logic       m_ready_x;
   logic [7:0] s_data_in_y;
   logic       s_valid_y;
   logic       s_ready_y;
   logic [2:0] rd_addr;
   logic [7:0] rd_data;
   logic       busy;
   logic       done;

   int checks;
   int failures;

   logic [7:0] x_vec [8];
   logic [7:0] y_vec [5];

   conv_stream_host #(.WIDTH(8), .LENX(8), .LENF(4), .LOGX(3)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .load_data    (load_data),
      .load_valid   (load_valid),
      .load_ready   (load_ready),
      .m_data_out_x (m_data_out_x),
      .m_valid_x    (m_valid_x),
      .m_ready_x    (m_ready_x),
      .s_data_in_y  (s_data_in_y),
      .s_valid_y    (s_valid_y),
      .s_ready_y    (s_ready_y),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data),
      .busy         (busy),
      .done         (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic checkIdleOutputs(input string tag);
      checkOutput({tag, "_load_ready"}, load_ready, 0);
      checkOutput({tag, "_m_valid_x"}, m_valid_x, 0);
      checkOutput({tag, "_m_data_x"}, m_data_out_x, 0);
      checkOutput({tag, "_s_ready_y"}, s_ready_y, 0);
      checkOutput({tag, "_busy"}, busy, 0);
      checkOutput({tag, "_done"}, done, 0);
   endtask

   // One full transaction. ready_toggle alternates m_ready_x, y_gap idles s_valid_y on
   // alternate cycles, poke_ignored drives inputs that the current state must ignore,
   // abort_at > 0 pulls reset low once that many x words have been sent.
   task automatic applyStimulus(input bit ready_toggle, input bit y_gap, input bit poke_ignored, input int abort_at);
      int sent;
      int got;
      int cyc;
      logic v;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checkOutput("start_load_ready", load_ready, 1);
      checkOutput("start_busy", busy, 1);
      for (int i = 0; i < 8; i++) begin
         load_data  = x_vec[i];
         load_valid = 1'b1;
         s_valid_y  = poke_ignored;
         s_data_in_y = 8'h99;
         checkOutput("load_s_ready_y", s_ready_y, 0);
         @(negedge clk);
      end
      load_valid = 1'b0;
      s_valid_y  = 1'b0;

      sent = 0;
      cyc  = 0;
      while (sent < 8 && cyc < 64) begin
         if (abort_at > 0 && sent == abort_at) begin
            rd_addr = 3'd0;
            reset = 1'b0;
            #1;
            checkOutput("abort_m_valid_x", m_valid_x, 0);
            checkOutput("abort_busy", busy, 0);
            checkOutput("abort_rd_data", rd_data, 0);
            m_ready_x = 1'b0;
            @(negedge clk);
            reset = 1'b1;
            repeat (3) @(negedge clk);
            checkIdleOutputs("after_abort");
            return;
         end
         checkOutput("x_valid", m_valid_x, 1);
         checkOutput("x_data", m_data_out_x, x_vec[sent]);
         checkOutput("x_s_ready_y", s_ready_y, 0);
         m_ready_x = ready_toggle ? (cyc % 2 == 0) : 1'b1;
         start     = poke_ignored;
         @(negedge clk);
         if (m_ready_x) sent++;
         cyc++;
      end
      m_ready_x = 1'b0;
      start     = 1'b0;
      checkOutput("x_sent_count", sent, 8);
      checkOutput("x_cycles", cyc, ready_toggle ? 15 : 8);

      checkOutput("recv_m_valid_x", m_valid_x, 0);
      got = 0;
      cyc = 0;
      while (got < 5 && cyc < 64) begin
         checkOutput("recv_s_ready_y", s_ready_y, 1);
         checkOutput("recv_done_early", done, 0);
         checkOutput("recv_load_ready", load_ready, 0);
         v = y_gap ? (cyc % 2 == 0) : 1'b1;
         s_valid_y   = v;
         s_data_in_y = v ? y_vec[got] : 8'hAA;
         load_valid  = poke_ignored;
         load_data   = 8'h55;
         @(negedge clk);
         if (v) got++;
         cyc++;
      end
      s_valid_y  = 1'b0;
      load_valid = 1'b0;
      checkOutput("y_got_count", got, 5);
      checkOutput("done_pulse", done, 1);
      checkOutput("done_busy", busy, 1);
      @(negedge clk);
      checkOutput("done_cleared", done, 0);
      checkIdleOutputs("post_done");

      for (int a = 0; a < 8; a++) begin
         rd_addr = 3'(a);
         @(negedge clk);
         checkOutput($sformatf("rd_data_%0d", a), rd_data, (a < 5) ? {24'd0, y_vec[a]} : 32'd0);
      end
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      reset       = 1'b1;
      start       = 1'b0;
      load_data   = 8'h00;
      load_valid  = 1'b0;
      m_ready_x   = 1'b0;
      s_data_in_y = 8'h00;
      s_valid_y   = 1'b0;
      rd_addr     = 3'd0;
      #2;
      reset = 1'b0;
      #1;
      checkIdleOutputs("reset");
      checkOutput("reset_rd_data", rd_data, 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;

      // load_valid before start must not begin anything.
      load_valid = 1'b1;
      @(negedge clk);
      load_valid = 1'b0;
      checkIdleOutputs("idle_load_valid");

      $display("[TB] basic flow");
      x_vec = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
      y_vec = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50};
      applyStimulus(1'b0, 1'b0, 1'b0, 0);

      $display("[TB] x backpressure");
      y_vec = '{8'd11, 8'd22, 8'd33, 8'd44, 8'd55};
      applyStimulus(1'b1, 1'b0, 1'b0, 0);

      $display("[TB] signed passthrough, y gaps, ignored inputs");
      x_vec = '{8'h80, 8'h7F, 8'hFF, 8'h00, 8'h05, 8'hFB, 8'h40, 8'hC0};
      y_vec = '{8'h80, 8'h7F, 8'h00, 8'hFF, 8'h03};
      applyStimulus(1'b0, 1'b1, 1'b1, 0);

      $display("[TB] reset mid-send");
      rd_addr = 3'd0;
      applyStimulus(1'b0, 1'b0, 1'b0, 3);
      x_vec = '{8'd21, 8'd22, 8'd23, 8'd24, 8'd25, 8'd26, 8'd27, 8'd28};
      y_vec = '{8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
      applyStimulus(1'b0, 1'b0, 1'b0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL timeout: got running, expected finished");
      $fatal(1, "[TB] timeout");
   end

endmodule
